// File: rtl/bidir_bus_ctrl_if.sv
// bidir_bus_ctrl_if: request/response and pad signals of one half-duplex tristate pad group.
// master = requester and pad side, slave = the controller.
interface bidir_bus_ctrl_if #(parameter int WIDTH = 8);
    logic             req_valid;
    logic             req_ready;
    logic             req_wr;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_rdata;
    logic             busy;
    logic             io_t;
    logic [WIDTH-1:0] io_o;
    logic [WIDTH-1:0] io_i;
    modport master (output req_valid, req_wr, req_wdata, io_i,
                    input  req_ready, rsp_valid, rsp_rdata, busy, io_t, io_o);
    modport slave  (input  req_valid, req_wr, req_wdata, io_i,
                    output req_ready, rsp_valid, rsp_rdata, busy, io_t, io_o);
endinterface

// File: rtl/bidir_bus_ctrl.sv
// bidir_bus_ctrl: half-duplex tristate pad sequencer with a write turnaround gap and timed read sampling.
// Define BIDIR_BUS_CTRL_SYNC_EN to pass io_i through a 2-flop synchronizer (adds 2 read cycles).
module bidir_bus_ctrl #(
    parameter int WIDTH    = 8,
    parameter int TURN_CYC = 1,
    parameter int RD_WAIT  = 2
) (
    input logic             clk,
    input logic             rst_n,
    bidir_bus_ctrl_if.slave bus
);
    logic [WIDTH-1:0] samp;
`ifdef BIDIR_BUS_CTRL_SYNC_EN
    localparam int RD_LEN = RD_WAIT + 2;
    logic [WIDTH-1:0] sync0, sync1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0 <= '0;
            sync1 <= '0;
        end else begin
            sync0 <= bus.io_i;
            sync1 <= sync0;
        end
    end
    assign samp = sync1;
`else
    localparam int RD_LEN = RD_WAIT;
    assign samp = bus.io_i;
`endif
    // Synchronized reads can need one extra counter bit for the longest RD_WAIT.
    localparam int CW = RD_LEN > 16 ? 5 : 4;
    typedef enum logic [1:0] {IDLE, WR, TURN, RD} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    assign bus.req_ready = state == IDLE;
    assign bus.busy      = state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.io_t      <= 1'b0;
            bus.io_o      <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: if (bus.req_valid) begin
                    state <= bus.req_wr ? WR : RD;
                    cnt   <= CW'(RD_LEN - 1);
                    if (bus.req_wr) begin
                        bus.io_t <= 1'b1;
                        bus.io_o <= bus.req_wdata;
                    end
                end
                WR: begin
                    state    <= TURN;
                    cnt      <= CW'(TURN_CYC - 1);
                    bus.io_t <= 1'b0;
                end
                TURN: if (cnt == '0) state <= IDLE; else cnt <= cnt - CW'(1);
                RD: if (cnt == '0) begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_rdata <= samp;
                end else begin
                    cnt <= cnt - CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// tb_bidir_bus_ctrl: randomized and directed checks of bidir_bus_ctrl against a transaction-level timing model.
module tb_bidir_bus_ctrl;
    localparam int W   = 8;
    localparam int TC  = 1;
    localparam int RW  = 2;
`ifdef BIDIR_BUS_CTRL_SYNC_EN
    localparam int SD  = 2;
`else
    localparam int SD  = 0;
`endif
    localparam int RDL = RW + SD;
    localparam int PN  = 8192;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bidir_bus_ctrl_if #(.WIDTH(W)) bus ();
    bidir_bus_ctrl #(.WIDTH(W), .TURN_CYC(TC), .RD_WAIT(RW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int m_ready_at = 0, m_iot_cyc = -1, m_rsp_cyc = -1, m_samp = 0;
    logic [W-1:0] m_io_o = '0, m_rdata = '0;
    logic [W-1:0] pad [0:PN-1];
    logic [W:0]   rq [$];
    logic         acc = 1'b0;

    // Model: a transaction accepted at the edge ending cycle c fixes its whole timeline from c.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready_at = cyc;
            m_iot_cyc  = -1;
            m_rsp_cyc  = -1;
            m_io_o     = '0;
            m_rdata    = '0;
        end else begin
            if (bus.req_valid && cyc >= m_ready_at) begin
                if (bus.req_wr) begin
                    m_iot_cyc  = cyc + 1;
                    m_io_o     = bus.req_wdata;
                    m_ready_at = cyc + 2 + TC;
                end else begin
                    m_rsp_cyc  = cyc + 1 + RDL;
                    m_ready_at = m_rsp_cyc;
                    m_samp     = m_rsp_cyc - 1 - SD;
                end
            end
            cyc++;
            if (cyc == m_rsp_cyc) m_rdata = pad[m_samp % PN];
        end
    end

    always @(negedge clk) pad[cyc % PN] = bus.io_i;

    function automatic logic [19:0] exp_vec();
        return {cyc >= m_ready_at, cyc < m_ready_at, cyc == m_iot_cyc, m_io_o, cyc == m_rsp_cyc, m_rdata};
    endfunction

    function automatic logic [19:0] obs_vec();
        return {bus.req_ready, bus.busy, bus.io_t, bus.io_o, bus.rsp_valid, bus.rsp_rdata};
    endfunction

    task automatic step(input logic [W-1:0] pin);
        @(posedge clk);
        #1;
        if (acc && rq.size() > 0) void'(rq.pop_front());
        bus.io_i = pin;
        bus.req_valid = rq.size() > 0;
        if (rq.size() > 0) {bus.req_wr, bus.req_wdata} = rq[0];
        @(negedge clk);
        acc = bus.req_valid && rst_n && cyc >= m_ready_at;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.req_ready, bus.busy, bus.io_t, bus.rsp_valid, bus.rsp_rdata} !== {4'b1000, 8'h00}) begin
            n_fail++;
            $display("FAIL reset got ready/busy/io_t/rsp/rdata=%b/%b/%b/%b/%h want 1/0/0/0/00",
                     bus.req_ready, bus.busy, bus.io_t, bus.rsp_valid, bus.rsp_rdata);
        end
    endtask

    task automatic test_write(input logic [W-1:0] d);
        rq.push_back({1'b1, d});
        for (int k = 0; k < 5; k++) begin
            step(W'($urandom));
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL write cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
            n_cmp++;
            if (bus.io_t !== (k == 1) || (k == 1 && bus.io_o !== d) || bus.req_ready !== (k == 0 || k >= 2 + TC)) begin
                n_fail++;
                $display("FAIL write_timing k=%0d got io_t=%b io_o=%h ready=%b want io_t=%b io_o=%h", k,
                         bus.io_t, bus.io_o, bus.req_ready, k == 1, d);
            end
        end
    endtask

    task automatic test_read();
        logic [W-1:0] v;
        v = SD != 0 ? 8'hC3 : 8'h3C;
        rq.push_back({1'b0, 8'h00});
        for (int k = 0; k < RDL + 3; k++) begin
            step(k == 0 ? W'($urandom) : v);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL read cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
            n_cmp++;
            if (bus.io_t !== 1'b0 || bus.rsp_valid !== (k == RDL + 1) || (k == RDL + 1 && bus.rsp_rdata !== v)) begin
                n_fail++;
                $display("FAIL read_timing k=%0d got io_t=%b rsp=%b rdata=%h want rsp=%b rdata=%h", k,
                         bus.io_t, bus.rsp_valid, bus.rsp_rdata, k == RDL + 1, v);
            end
        end
    endtask

    task automatic test_back_to_back();
        int iot_k [$];
        int rsp_k;
        logic [W-1:0] pv [0:15];
        logic [W-1:0] got;
        rsp_k = -1;
        got = '0;
        rq.push_back({1'b1, 8'h11});
        rq.push_back({1'b0, 8'h00});
        rq.push_back({1'b1, 8'h22});
        for (int k = 0; k < 12; k++) begin
            pv[k] = W'($urandom);
            step(pv[k]);
            if (bus.io_t) iot_k.push_back(k);
            if (bus.rsp_valid) begin
                rsp_k = k;
                got = bus.rsp_rdata;
            end
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL b2b cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (iot_k.size() != 2 || rsp_k != 3 + TC + RDL || iot_k[0] != 1 || iot_k[1] != rsp_k + 1) begin
            n_fail++;
            $display("FAIL b2b_timing got io_t pulses=%0d rsp_k=%0d want 2 pulses at 1,%0d rsp_k=%0d",
                     iot_k.size(), rsp_k, 4 + TC + RDL, 3 + TC + RDL);
        end else begin
            n_cmp++;
            if (got !== pv[rsp_k - 1 - SD]) begin
                n_fail++;
                $display("FAIL b2b_rdata got=%h want=%h", got, pv[rsp_k - 1 - SD]);
            end
        end
    endtask

    task automatic test_mid_reset();
        rq.push_back({1'b1, 8'h77});
        step(W'($urandom));
        step(W'($urandom));
        n_cmp++;
        if (bus.io_t !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_wr got io_t=%b want 1", bus.io_t);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.io_t !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async got io_t=%b busy=%b want 0/0", bus.io_t, bus.busy);
        end
        rq.delete();
        acc = 1'b0;
        repeat (2) step(W'($urandom));
        rst_n = 1'b1;
        rq.push_back({1'b0, 8'h00});
        step(W'($urandom));
        step(W'($urandom));
        rst_n = 1'b0;
        rq.delete();
        acc = 1'b0;
        step(W'($urandom));
        rst_n = 1'b1;
        for (int k = 0; k < RDL + 3; k++) begin
            step(W'($urandom));
            n_cmp++;
            if (bus.rsp_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL midrst_norsp cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
        end
        test_write(8'hA5);
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            if (rq.size() == 0 && $urandom_range(0, 1) == 1)
                rq.push_back({1'($urandom_range(0, 1)), W'($urandom)});
            step(W'($urandom));
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_wdata = '0;
        bus.io_i      = '0;
        test_reset();
        test_write(8'hA5);
        test_read();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
